// File: rtl/pio_in_edge.sv
// Avalon-MM input PIO with synchroniser, per-bit debounce,
// edge capture (write-1-to-clear), interrupt mask and level IRQ.
module pio_in_edge #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0][CW-1:0]          cnt_q, cnt_d;
    logic [WIDTH-1:0]                  stable_q, stable_d;
    logic [WIDTH-1:0]                  cap_q, cap_d;
    logic [WIDTH-1:0]                  irq_mask_q, irq_mask_d;
    logic [31:0]                       readdata_q, readdata_d;
    logic                              irq_q, irq_d;

    logic [WIDTH-1:0] sync_out;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] new_edge;
    logic [WIDTH-1:0] w1c;
    logic             wr_sel;
    logic             unused_wd;

    // Only writedata[WIDTH-1:0] is meaningful; fold the rest away.
    assign unused_wd = ^writedata;

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign wr_sel   = chipselect & write;

    // Shift raw inputs through the synchroniser chain.
    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = in_port;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // Per-bit debounce: accept a new level after it persists long enough.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync_out[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                stable_d[i] = sync_out[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    // Qualify stable transitions according to the capture mode.
    always_comb begin
        rise = stable_d & ~stable_q;
        fall = stable_q & ~stable_d;
        case (EDGE_TYPE)
            0:       new_edge = rise;
            1:       new_edge = fall;
            default: new_edge = rise | fall;
        endcase
    end

    // Register writes, edge capture with set-over-clear, and IRQ level.
    always_comb begin
        irq_mask_d = irq_mask_q;
        w1c        = '0;
        if (wr_sel && address == 2'd2) begin
            irq_mask_d = writedata[WIDTH-1:0];
        end
        if (wr_sel && address == 2'd3) begin
            w1c = writedata[WIDTH-1:0];
        end
        cap_d = (cap_q & ~w1c) | new_edge;
        irq_d = |(cap_d & irq_mask_d);
    end

    // Read mux, registered every cycle regardless of chipselect.
    always_comb begin
        case (address)
            2'd0:    readdata_d = 32'(stable_q);
            2'd1:    readdata_d = '0;
            2'd2:    readdata_d = 32'(irq_mask_q);
            default: readdata_d = 32'(cap_q);
        endcase
    end

    // State update; reset wins over any concurrent bus write.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q     <= '0;
            cnt_q      <= '0;
            stable_q   <= '0;
            cap_q      <= '0;
            irq_mask_q <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            cnt_q      <= cnt_d;
            stable_q   <= stable_d;
            cap_q      <= cap_d;
            irq_mask_q <= irq_mask_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_pio_in_edge.sv
// Directed scoreboard bench for pio_in_edge across four
// parameter sets (rising, debounced any-edge, 32-bit, falling).
module tb_pio_in_edge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst [4];
    logic [1:0]  addr[4];
    logic        cs  [4];
    logic        we  [4];
    logic [31:0] wd  [4];
    logic [31:0] rd  [4];
    logic        irq [4];

    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic [31:0] in_c;
    logic [3:0]  in_d;

    pio_in_edge #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .EDGE_TYPE(0)) u0 (
        .clk(clk), .reset(rst[0]), .address(addr[0]), .chipselect(cs[0]),
        .write(we[0]), .writedata(wd[0]), .readdata(rd[0]),
        .in_port(in_a), .irq(irq[0]));

    pio_in_edge #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2)) u1 (
        .clk(clk), .reset(rst[1]), .address(addr[1]), .chipselect(cs[1]),
        .write(we[1]), .writedata(wd[1]), .readdata(rd[1]),
        .in_port(in_b), .irq(irq[1]));

    pio_in_edge #(.WIDTH(32), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(1), .EDGE_TYPE(0)) u2 (
        .clk(clk), .reset(rst[2]), .address(addr[2]), .chipselect(cs[2]),
        .write(we[2]), .writedata(wd[2]), .readdata(rd[2]),
        .in_port(in_c), .irq(irq[2]));

    pio_in_edge #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .EDGE_TYPE(1)) u3 (
        .clk(clk), .reset(rst[3]), .address(addr[3]), .chipselect(cs[3]),
        .write(we[3]), .writedata(wd[3]), .readdata(rd[3]),
        .in_port(in_d), .irq(irq[3]));

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic push(input string tag, input logic [31:0] e);
        exp_t x;
        x.tag = tag;
        x.exp = e;
        sb.push_back(x);
    endtask

    task automatic pop(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $error("FAIL sb_empty observed=%h expected=none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int d, input logic [1:0] a, input logic [31:0] data);
        addr[d] = a;
        wd[d]   = data;
        cs[d]   = 1'b1;
        we[d]   = 1'b1;
        tick();
        cs[d]   = 1'b0;
        we[d]   = 1'b0;
    endtask

    task automatic rd_chk(input int d, input logic [1:0] a, input logic [31:0] e,
                          input string tag);
        addr[d] = a;
        push(tag, e);
        tick();
        pop(rd[d]);
    endtask

    task automatic irq_chk(input int d, input logic e, input string tag);
        push(tag, 32'(e));
        pop(32'(irq[d]));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 4; d++) begin
            rst[d]  = 1'b1;
            addr[d] = 2'd0;
            cs[d]   = 1'b0;
            we[d]   = 1'b0;
            wd[d]   = '0;
        end
        in_a = 8'h00;
        in_b = 8'h00;
        in_c = 32'hFFFF_FFFF;
        in_d = 4'hF;
        tick();
        tick();

        // Reset state on every instance
        for (int d = 0; d < 4; d++) begin
            irq_chk(d, 1'b0, "rst_irq");
            push("rst_rd", 32'h0);
            pop(rd[d]);
        end
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        rst[3] = 1'b0;

        // u0: register reads after reset
        rd_chk(0, 2'd0, 32'h0, "u0_rst_data");
        rd_chk(0, 2'd1, 32'h0, "u0_rst_rsvd");
        rd_chk(0, 2'd2, 32'h0, "u0_rst_mask");
        rd_chk(0, 2'd3, 32'h0, "u0_rst_cap");

        // u0: latency 0x00 -> 0xA5, readdata first at edge 3
        addr[0] = 2'd0;
        in_a    = 8'hA5;
        for (int k = 0; k < 4; k++) begin
            push($sformatf("u0_lat_e%0d", k), (k == 3) ? 32'hA5 : 32'h0);
            tick();
            pop(rd[0]);
        end
        rd_chk(0, 2'd3, 32'hA5, "u0_cap_a5");
        irq_chk(0, 1'b0, "u0_irq_masked");

        // u0: ignored writes, W1C, mask upper bits
        wr(0, 2'd0, 32'hFF);
        rd_chk(0, 2'd0, 32'hA5, "u0_data_ro");
        wr(0, 2'd1, 32'hFF);
        rd_chk(0, 2'd1, 32'h0, "u0_rsvd_ro");
        wr(0, 2'd3, 32'hFF);
        rd_chk(0, 2'd3, 32'h0, "u0_w1c_all");
        wr(0, 2'd2, 32'hFFFF_FF01);
        rd_chk(0, 2'd2, 32'h01, "u0_mask_trunc");
        irq_chk(0, 1'b0, "u0_irq_nocap");

        // u0: fall not captured in rising mode, then rise -> irq
        in_a = 8'hA4;
        repeat (4) tick();
        irq_chk(0, 1'b0, "u0_fall_irq");
        rd_chk(0, 2'd3, 32'h0, "u0_fall_cap");
        in_a = 8'hA5;
        for (int k = 0; k < 3; k++) begin
            push($sformatf("u0_irq_e%0d", k), 32'(k == 2));
            tick();
            pop(32'(irq[0]));
        end
        wr(0, 2'd3, 32'h01);
        irq_chk(0, 1'b0, "u0_irq_w1c");
        rd_chk(0, 2'd3, 32'h0, "u0_cap_w1c");

        // u1: 3-cycle glitch on bit 2 is filtered
        wr(1, 2'd2, 32'hFF);
        in_b = 8'h04;
        repeat (3) tick();
        in_b = 8'h00;
        for (int k = 3; k < 9; k++) begin
            tick();
            irq_chk(1, 1'b0, $sformatf("u1_glitch_e%0d", k));
        end
        rd_chk(1, 2'd0, 32'h0, "u1_glitch_data");
        rd_chk(1, 2'd3, 32'h0, "u1_glitch_cap");

        // u1: 4-cycle hold accepted at edge 5
        in_b = 8'h04;
        for (int k = 0; k < 6; k++) begin
            push($sformatf("u1_hold_e%0d", k), 32'(k == 5));
            tick();
            pop(32'(irq[1]));
        end
        rd_chk(1, 2'd0, 32'h04, "u1_hold_data");
        rd_chk(1, 2'd3, 32'h04, "u1_hold_cap");

        // u1: any-edge on bit 1, set wins over same-cycle W1C
        in_b = 8'h06;
        repeat (7) tick();
        rd_chk(1, 2'd3, 32'h06, "u1_rise_b1");
        wr(1, 2'd3, 32'h02);
        rd_chk(1, 2'd3, 32'h04, "u1_w1c_b1");
        in_b = 8'h04;
        repeat (5) tick();
        wr(1, 2'd3, 32'h06);
        irq_chk(1, 1'b1, "u1_coinc_irq");
        rd_chk(1, 2'd3, 32'h02, "u1_set_wins");
        wr(1, 2'd2, 32'h0);
        irq_chk(1, 1'b0, "u1_unmask_irq");
        rd_chk(1, 2'd3, 32'h02, "u1_cap_kept");

        // u2: all inputs high through reset release
        rst[2]  = 1'b0;
        addr[2] = 2'd2;
        wd[2]   = 32'hFFFF_FFFF;
        cs[2]   = 1'b1;
        we[2]   = 1'b1;
        push("u2_irq_e0", 32'h0);
        tick();
        pop(32'(irq[2]));
        cs[2]   = 1'b0;
        we[2]   = 1'b0;
        addr[2] = 2'd3;
        for (int k = 1; k < 5; k++) begin
            push($sformatf("u2_irq_e%0d", k), 32'(k >= 3));
            push($sformatf("u2_cap_e%0d", k), (k >= 4) ? 32'hFFFF_FFFF : 32'h0);
            tick();
            pop(32'(irq[2]));
            pop(rd[2]);
        end
        rd_chk(2, 2'd2, 32'hFFFF_FFFF, "u2_mask32");

        // u2: reset mid-operation with a concurrent write
        rst[2]  = 1'b1;
        addr[2] = 2'd2;
        wd[2]   = 32'hFFFF_FFFF;
        cs[2]   = 1'b1;
        we[2]   = 1'b1;
        push("u2_rst_irq", 32'h0);
        push("u2_rst_rd", 32'h0);
        tick();
        pop(32'(irq[2]));
        pop(rd[2]);
        cs[2]   = 1'b0;
        we[2]   = 1'b0;
        rst[2]  = 1'b0;
        rd_chk(2, 2'd2, 32'h0, "u2_rst_mask");
        rd_chk(2, 2'd3, 32'h0, "u2_rst_cap");

        // u3: falling-edge mode, 4-bit width
        rd_chk(3, 2'd3, 32'h0, "u3_rise_ignored");
        rd_chk(3, 2'd0, 32'hF, "u3_data");
        in_d = 4'h3;
        repeat (4) tick();
        rd_chk(3, 2'd3, 32'hC, "u3_fall_cap");
        wr(3, 2'd2, 32'hFFFF_FFFF);
        irq_chk(3, 1'b1, "u3_irq");
        rd_chk(3, 2'd2, 32'hF, "u3_mask_trunc");

        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL sb_leftover observed=%0d expected=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
